// File: rtl/serializador_piso.sv
// serializador_piso: parallel-in/serial-out transmitter.
// Captures an N-bit word on a load handshake and shifts it out one bit
// per enabled clock. fin pulses for one cycle after the last bit goes out.
// All outputs are registered.
module serializador_piso #(
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic [N-1:0] D,
  input  logic         load,
  output logic         listo,
  output logic         Q_serie,
  output logic         valido,
  output logic         fin
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [N-1:0]   sr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   sr_nx;

  // Bit presented on the serial line for a given shift-register image
  function automatic logic head(input logic [N-1:0] v);
    return LSB_FIRST ? v[0] : v[N-1];
  endfunction

  // Shift toward the output end, zero-filled
  always_comb begin
    sr_nx = LSB_FIRST ? (sr >> 1) : (sr << 1);
  end

  // Control FSM; Q_serie is kept as a registered copy of the head bit so
  // that a stalled word holds its output without any combinational path
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      Q_serie <= 1'b0;
      valido  <= 1'b0;
      listo   <= 1'b1;
      fin     <= 1'b0;
    end else begin
      fin <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            sr      <= D;
            cnt     <= CW'(N);
            state   <= SHIFT;
            listo   <= 1'b0;
            valido  <= 1'b1;
            Q_serie <= head(D);
          end
        end
        SHIFT: begin
          if (EN) begin
            sr  <= sr_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state   <= IDLE;
              fin     <= 1'b1;
              valido  <= 1'b0;
              listo   <= 1'b1;
              Q_serie <= 1'b0;
            end else begin
              Q_serie <= head(sr_nx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
